// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 accumulator/ALU slice.
// Latency and backpressure: none, declarations only.
package sap1_pkg;
   localparam int SAP1_WIDTH = 8;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      WRITE = 2'd2
   } alu_state_t;
endpackage

// File: rtl/alu_accumulator_if.sv
// Bus/control bundle between the SAP-1 controller side and the accumulator/ALU.
// Latency and backpressure: wires only; busy tells the master when start/load are ignored.
interface alu_accumulator_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] data_bus;
   logic             load_acc;
   logic [WIDTH-1:0] regb_value;
   logic             start;
   logic             subtract;
   logic             enable_output;
   logic [WIDTH-1:0] acc_value;
   logic [WIDTH-1:0] alu_bus_out;
   logic             alu_bus_drive;
   logic             busy;
   logic             done;
   logic             carry_flag;
   logic             zero_flag;

   modport master (
      output data_bus, load_acc, regb_value, start, subtract, enable_output,
      input  acc_value, alu_bus_out, alu_bus_drive, busy, done, carry_flag, zero_flag
   );

   modport slave (
      input  data_bus, load_acc, regb_value, start, subtract, enable_output,
      output acc_value, alu_bus_out, alu_bus_drive, busy, done, carry_flag, zero_flag
   );
endinterface

// File: rtl/adder_subtractor.sv
// Combinational A+B / A-B with carry out (carry = no-borrow when subtracting).
// Latency 0; no backpressure.
import sap1_pkg::*;

module adder_subtractor #(
   parameter int WIDTH = SAP1_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH:0]   sum
);
   logic [WIDTH-1:0] b_eff;

   // Two's-complement subtract: invert B and inject the +1 as carry-in.
   assign b_eff = (sub == OP_SUB) ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
endmodule

// File: rtl/alu_accumulator.sv
// SAP-1 accumulator + adder/subtractor: start sampled in IDLE, flags after 1 cycle, A written after 2.
// start/load_acc are dropped (not queued) while busy; bus output is combinational gating of result_reg.
import sap1_pkg::*;

module alu_accumulator #(
   parameter int WIDTH = SAP1_WIDTH
) (
   input logic              Clock,
   input logic              Reset,
   alu_accumulator_if.slave bus
);
   alu_state_t       state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] operand_b;
   logic             op_sub;
   logic [WIDTH-1:0] result_reg;
   logic             carry_flag;
   logic             zero_flag;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   sum;

   adder_subtractor #(.WIDTH(WIDTH)) u_addsub (
      .a   (acc),
      .b   (operand_b),
      .sub (op_sub),
      .sum (sum)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         acc        <= '0;
         operand_b  <= '0;
         op_sub     <= OP_ADD;
         result_reg <= '0;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (bus.load_acc) begin
                  acc <= bus.data_bus;
               end
               if (bus.start) begin
                  operand_b <= bus.regb_value;
                  op_sub    <= bus.subtract;
                  busy      <= 1'b1;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               result_reg <= sum[WIDTH-1:0];
               carry_flag <= sum[WIDTH];
               zero_flag  <= (sum[WIDTH-1:0] == '0);
               done       <= 1'b1;
               state      <= WRITE;
            end
            WRITE: begin
               acc   <= result_reg;
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.acc_value     = acc;
   assign bus.carry_flag    = carry_flag;
   assign bus.zero_flag     = zero_flag;
   assign bus.busy          = busy;
   assign bus.done          = done;
   assign bus.alu_bus_drive = bus.enable_output;
   assign bus.alu_bus_out   = bus.enable_output ? result_reg : '0;
endmodule

// File: tb/tb_alu_accumulator.sv
// Bench for alu_accumulator: directed vector table, hazard/reset/gating sequences,
// then random operations compared against an integer-arithmetic reference model.
module tb_alu_accumulator;
   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   m_acc;

   always #5 Clock = ~Clock;

   alu_accumulator_if #(.WIDTH(8)) bus ();

   alu_accumulator #(.WIDTH(8)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] r;
      logic       c;
      logic       z;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic; carry is overflow for add, A>=B for subtract.
   task automatic model(input int a, input int b, input bit sub,
                        output int r, output bit c, output bit z);
      int s;
      if (sub) begin
         s = a - b;
         c = (a >= b);
      end else begin
         s = a + b;
         c = (s > 255);
      end
      r = s & 255;
      z = (r == 0);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input bit do_load, input logic [7:0] er, input logic ec,
                         input logic ez);
      if (do_load) begin
         bus.data_bus = a;
         bus.load_acc = 1'b1;
         tick();
         bus.load_acc = 1'b0;
      end
      bus.regb_value = b;
      bus.subtract   = sub;
      bus.start      = 1'b1;
      tick();
      bus.start      = 1'b0;
      bus.regb_value = 8'($urandom);
      bus.subtract   = ~sub;
      chk("busy_exec", 32'(bus.busy), 1);
      chk("done_exec", 32'(bus.done), 0);
      tick();
      chk("done_write", 32'(bus.done), 1);
      chk("busy_write", 32'(bus.busy), 1);
      chk("carry", 32'(bus.carry_flag), 32'(ec));
      chk("zero", 32'(bus.zero_flag), 32'(ez));
      tick();
      chk("done_idle", 32'(bus.done), 0);
      chk("busy_idle", 32'(bus.busy), 0);
      chk("acc", 32'(bus.acc_value), 32'(er));
   endtask

   initial begin
      bus.data_bus      = '0;
      bus.load_acc      = 1'b0;
      bus.regb_value    = '0;
      bus.start         = 1'b0;
      bus.subtract      = 1'b0;
      bus.enable_output = 1'b0;

      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[2] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b1};
      vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0};

      tick();
      tick();
      chk("rst_acc", 32'(bus.acc_value), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_carry", 32'(bus.carry_flag), 0);
      chk("rst_zero", 32'(bus.zero_flag), 0);
      Reset = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1, vecs[i].r, vecs[i].c, vecs[i].z);
      end

      // Output gating after 05+03.
      run_op(8'h05, 8'h03, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
      bus.enable_output = 1'b0;
      #1;
      chk("gate_off_out", 32'(bus.alu_bus_out), 0);
      chk("gate_off_drv", 32'(bus.alu_bus_drive), 0);
      bus.enable_output = 1'b1;
      #1;
      chk("gate_on_out", 32'(bus.alu_bus_out), 32'h08);
      chk("gate_on_drv", 32'(bus.alu_bus_drive), 1);
      bus.enable_output = 1'b0;

      // start/load pulsed through EXEC and WRITE must be dropped.
      bus.data_bus = 8'h05;
      bus.load_acc = 1'b1;
      tick();
      bus.load_acc   = 1'b0;
      bus.regb_value = 8'h03;
      bus.subtract   = 1'b0;
      bus.start      = 1'b1;
      tick();
      bus.data_bus   = 8'h10;
      bus.load_acc   = 1'b1;
      bus.regb_value = 8'h7F;
      tick();
      tick();
      bus.start    = 1'b0;
      bus.load_acc = 1'b0;
      chk("hz_acc", 32'(bus.acc_value), 32'h08);
      tick();
      chk("hz_busy", 32'(bus.busy), 0);
      chk("hz_acc_hold", 32'(bus.acc_value), 32'h08);

      // load + start in the same cycle: EXEC sees the new A.
      bus.data_bus   = 8'h20;
      bus.load_acc   = 1'b1;
      bus.regb_value = 8'h01;
      bus.subtract   = 1'b0;
      bus.start      = 1'b1;
      tick();
      bus.load_acc = 1'b0;
      bus.start    = 1'b0;
      chk("both_busy", 32'(bus.busy), 1);
      tick();
      tick();
      chk("both_acc", 32'(bus.acc_value), 32'h21);

      // Reset mid-EXEC, with flags previously set by a wrap.
      run_op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
      bus.data_bus = 8'h05;
      bus.load_acc = 1'b1;
      tick();
      bus.load_acc   = 1'b0;
      bus.regb_value = 8'h03;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      Reset     = 1'b1;
      #1;
      chk("mid_rst_acc", 32'(bus.acc_value), 0);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_done", 32'(bus.done), 0);
      chk("mid_rst_carry", 32'(bus.carry_flag), 0);
      chk("mid_rst_zero", 32'(bus.zero_flag), 0);
      tick();
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_done", 32'(bus.done), 0);
         chk("post_rst_acc", 32'(bus.acc_value), 0);
      end
      bus.enable_output = 1'b1;
      #1;
      chk("post_rst_result", 32'(bus.alu_bus_out), 0);
      bus.enable_output = 1'b0;

      m_acc = 0;
      for (int i = 0; i < 60; i++) begin
         int  a, b, r;
         bit  sub, c, z, do_load;
         do_load = 1'($urandom);
         a       = do_load ? int'($urandom_range(0, 255)) : m_acc;
         b       = int'($urandom_range(0, 255));
         sub     = 1'($urandom);
         model(a, b, sub, r, c, z);
         run_op(8'(a), 8'(b), sub, do_load, 8'(r), c, z);
         m_acc = r;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
